branch_sequencer: RTL
=====================

Name: branch_sequencer

Overview:
- Multi-cycle controller that sequences control-transfer instructions in the RISC core.
- Accepts a decoded branch/call/return request from the decode stage and evaluates the condition against its own latched ALU flag register.
- Computes the target, owns the return-address register, and issues a one-cycle PC load plus pipeline flush to fetch.
- Sits between decode, the ALU flag outputs and the PC register.

Parameters:
- ADDR_W, 22, width of the branch offset field.
- PC_W, 32, width of PC, target and return address.
- RAS_DEPTH, 4, return-address stack entries (used only with RA_STACK_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  decode presents a control-transfer instruction.
- req_ready  out  1  sequencer can accept a request.
- req_func  in  4  0 CALL, 1 BNO, 2 BO, 3 BNS, 4 BS, 5 BNC, 6 BC, 7 BNZ, 8 BZ, 9 BR, 10 RET; 11-15 illegal.
- req_addr  in  ADDR_W  signed two's-complement PC-relative offset.
- req_pc  in  PC_W  PC of the requesting instruction.
- flag_we  in  1  ALU flag write strobe.
- flag_in  in  4  {carry, sign, overflow, zero}.
- pc_load  out  1  one-cycle strobe: load pc_target into PC.
- pc_target  out  PC_W  next PC.
- flush  out  1  one-cycle strobe: squash younger fetched instructions.
- done  out  1  one-cycle strobe: request retired, taken or not.
- taken  out  1  qualifies done; condition was true.
- illegal  out  1  one-cycle strobe with done for func 11-15.
- ra_out  out  PC_W  current return address (top of stack when RA_STACK_EN).

Behaviour:
- Reset values: all outputs 0 except req_ready=1. Internal flags, ra and state IDLE also reset to 0.
- Handshake: transfer occurs when req_valid && req_ready. req_ready=1 only in IDLE. Request fields are latched on transfer.
- FSM IDLE -> EVAL -> COMMIT -> IDLE; each state lasts 1 cycle, so the accept-to-done latency is 2 cycles.
- Back-to-back throughput is 1 request per 3 cycles.
- IDLE: wait for the handshake.
- EVAL: evaluate the condition from the flag register and compute the target. A flag_we in the accept cycle is visible. A flag_we during EVAL or COMMIT updates the flag register but does not affect the branch in flight.
- COMMIT: assert done. If taken: pc_load=1, flush=1, pc_target=computed target. If not taken: pc_load=0, flush=0, pc_target holds its previous value.
- Conditions: BNO=!V, BO=V, BNS=!S, BS=S, BNC=!C, BC=C, BNZ=!Z, BZ=Z. CALL, BR and RET are always taken.
- Target for CALL and Bxx: req_pc + sign_extend(req_addr), truncated modulo 2^PC_W (wrap-around allowed).
- Target for RET: current ra.
- CALL: ra <= req_pc + 1 in COMMIT.
- Illegal func: done=1, illegal=1, taken=0; no PC or ra change.
- Flag register: loads flag_in on every flag_we, in any state.
- rst asserted mid-operation: FSM returns to IDLE immediately. All strobes drop asynchronously; no partial commit occurs.

Optional Feature:
- Macro: BRANCH_SEQUENCER_RA_STACK_EN.
- Defined: ra becomes a RAS_DEPTH-entry circular stack.
  - CALL pushes req_pc+1; RET pops and jumps to the popped value.
  - Push when full overwrites the oldest entry.
  - Pop when empty yields target 0 and asserts illegal with done; RET is still taken.
  - ra_out shows the top of stack, or 0 when empty.
- Undefined: single ra register. CALL overwrites it; RET reads it and leaves it unchanged.

Decomposition:
- Shared package branch_pkg holds:
  - func encodings (FN_CALL … FN_RET) and flag bit indices (FLG_C, FLG_S, FLG_V, FLG_Z);
  - FSM state typedef.
- One sub-module, branch_cond: combinational decision from func and flags producing taken and illegal. Reusable by the jump unit datapath.

Test Plan:
- CALL, req_pc=5, addr=12 -> done 2 cycles after accept, taken=1, pc_target=17, ra_out=6, flush=1.
- BZ, req_pc=1, addr=25, flags Z=1 -> pc_target=26, taken=1. Same request with Z=0 -> taken=0, pc_load=0, done=1.
- BC with flag_we C=1 in the accept cycle -> taken. BC with flag_we C=1 only in EVAL -> not taken; a following BC is taken.
- BR, req_pc=1, addr=22'h3FFFFE (-2) -> pc_target=32'hFFFFFFFF (wrap).
- CALL pc=5, then RET pc=40 -> RET pc_target=6. func=12 -> illegal=1, no pc_load. With RA_STACK_EN, depth 4: 5 CALLs then 5 RETs -> last RET illegal, target 0.
- rst pulse during EVAL -> no done/pc_load, req_ready=1 next cycle, flags and ra = 0.

Source files
------------

// File: rtl/branch_sequencer_pkg.sv
// Shared encodings for the branch sequencer: function codes, flag bit positions
// and FSM state constants.
package branch_pkg;

   localparam logic [3:0] FN_CALL = 4'd0;
   localparam logic [3:0] FN_BNO  = 4'd1;
   localparam logic [3:0] FN_BO   = 4'd2;
   localparam logic [3:0] FN_BNS  = 4'd3;
   localparam logic [3:0] FN_BS   = 4'd4;
   localparam logic [3:0] FN_BNC  = 4'd5;
   localparam logic [3:0] FN_BC   = 4'd6;
   localparam logic [3:0] FN_BNZ  = 4'd7;
   localparam logic [3:0] FN_BZ   = 4'd8;
   localparam logic [3:0] FN_BR   = 4'd9;
   localparam logic [3:0] FN_RET  = 4'd10;

   // Positions inside the {carry, sign, overflow, zero} flag word
   localparam int FLG_C = 3;
   localparam int FLG_S = 2;
   localparam int FLG_V = 1;
   localparam int FLG_Z = 0;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_EVAL   = 2'd1;
   localparam state_t ST_COMMIT = 2'd2;

endpackage

// File: rtl/branch_sequencer_cond.sv
// Combinational branch decision: maps a function code and the ALU flags to
// taken/illegal. Kept standalone so the jump unit datapath can share it.
module branch_cond
   import branch_pkg::*;
(
   input  logic [3:0] func,
   input  logic [3:0] flags,
   output logic       taken,
   output logic       illegal
);

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (func)
         FN_CALL, FN_BR, FN_RET: taken = 1'b1;
         FN_BNO:  taken = ~flags[FLG_V];
         FN_BO:   taken =  flags[FLG_V];
         FN_BNS:  taken = ~flags[FLG_S];
         FN_BS:   taken =  flags[FLG_S];
         FN_BNC:  taken = ~flags[FLG_C];
         FN_BC:   taken =  flags[FLG_C];
         FN_BNZ:  taken = ~flags[FLG_Z];
         FN_BZ:   taken =  flags[FLG_Z];
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_sequencer.sv
// Control-transfer sequencer: IDLE -> EVAL -> COMMIT, owns the flag register and
// return address. Define BRANCH_SEQUENCER_RA_STACK_EN for a circular return stack.
module branch_sequencer
   import branch_pkg::*;
#(
   parameter int ADDR_W    = 22,
   parameter int PC_W      = 32,
   parameter int RAS_DEPTH = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_func,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [PC_W-1:0]   req_pc,
   input  logic              flag_we,
   input  logic [3:0]        flag_in,
   output logic              pc_load,
   output logic [PC_W-1:0]   pc_target,
   output logic              flush,
   output logic              done,
   output logic              taken,
   output logic              illegal,
   output logic [PC_W-1:0]   ra_out
);

   state_t            state_reg;
   logic [3:0]        func_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [PC_W-1:0]   pc_reg;
   logic [3:0]        flag_reg;
   logic              taken_reg;
   logic              illegal_reg;
   logic [PC_W-1:0]   target_reg;
   logic [PC_W-1:0]   pc_target_reg;

   logic              accept;
   logic              commit;
   logic              cond_taken;
   logic              cond_illegal;
   logic              ra_underflow;
   logic [PC_W-1:0]   ra_top;
   logic [PC_W-1:0]   rel_target;
   logic [PC_W-1:0]   ret_addr;

   assign req_ready = (state_reg == ST_IDLE);
   assign accept    = req_valid && req_ready;
   assign commit    = (state_reg == ST_COMMIT);

   assign rel_target = pc_reg + {{(PC_W-ADDR_W){addr_reg[ADDR_W-1]}}, addr_reg};
   assign ret_addr   = pc_reg + PC_W'(1);

   branch_cond u_cond (
      .func    (func_reg),
      .flags   (flag_reg),
      .taken   (cond_taken),
      .illegal (cond_illegal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE:   if (accept) state_reg <= ST_EVAL;
            ST_EVAL:   state_reg <= ST_COMMIT;
            ST_COMMIT: state_reg <= ST_IDLE;
            default:   state_reg <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         func_reg <= '0;
         addr_reg <= '0;
         pc_reg   <= '0;
      end else if (accept) begin
         func_reg <= req_func;
         addr_reg <= req_addr;
         pc_reg   <= req_pc;
      end
   end

   // Updated in any state; EVAL samples it, so only writes up to the accept edge count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_reg <= '0;
      end else if (flag_we) begin
         flag_reg <= flag_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         taken_reg   <= 1'b0;
         illegal_reg <= 1'b0;
         target_reg  <= '0;
      end else if (state_reg == ST_EVAL) begin
         taken_reg   <= cond_taken;
         illegal_reg <= cond_illegal || ((func_reg == FN_RET) && ra_underflow);
         target_reg  <= (func_reg == FN_RET) ? ra_top : rel_target;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_target_reg <= '0;
      end else if (commit && taken_reg) begin
         pc_target_reg <= target_reg;
      end
   end

   assign done      = commit;
   assign taken     = commit && taken_reg;
   assign illegal   = commit && illegal_reg;
   assign pc_load   = commit && taken_reg;
   assign flush     = commit && taken_reg;
   assign pc_target = (commit && taken_reg) ? target_reg : pc_target_reg;
   assign ra_out    = ra_top;

`ifdef BRANCH_SEQUENCER_RA_STACK_EN
   localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(RAS_DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

   logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] top_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [PTR_W-1:0] push_ptr;
   logic [PTR_W-1:0] pop_ptr;

   assign ra_underflow = (count_reg == '0);
   assign ra_top       = ra_underflow ? '0 : ras_mem[top_ptr_reg];
   assign push_ptr     = (top_ptr_reg == PTR_MAX) ? '0 : top_ptr_reg + PTR_W'(1);
   assign pop_ptr      = (top_ptr_reg == '0) ? PTR_MAX : top_ptr_reg - PTR_W'(1);

   // A push on a full stack simply overwrites the oldest slot as the pointer wraps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
         top_ptr_reg <= '0;
         count_reg   <= '0;
      end else if (commit) begin
         if (func_reg == FN_CALL) begin
            ras_mem[push_ptr] <= ret_addr;
            top_ptr_reg       <= push_ptr;
            if (count_reg != CNT_MAX) count_reg <= count_reg + CNT_W'(1);
         end else if ((func_reg == FN_RET) && !ra_underflow) begin
            top_ptr_reg <= pop_ptr;
            count_reg   <= count_reg - CNT_W'(1);
         end
      end
   end
`else
   logic [PC_W-1:0] ra_reg;

   assign ra_underflow = 1'b0;
   assign ra_top       = ra_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ra_reg <= '0;
      end else if (commit && (func_reg == FN_CALL)) begin
         ra_reg <= ret_addr;
      end
   end
`endif

endmodule
